// File: rtl/gray_seq_ctrl.sv
// Command-driven step sequencer: a WIDTH-bit binary counter stepped a programmed
// number of times at a prescaled rate, published as both binary and Gray code.
module gray_seq_ctrl #(
    parameter int WIDTH = 8,
    parameter int PRE_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_len,
    input  logic [WIDTH-1:0] cmd_val,
    input  logic [PRE_W-1:0] prescale,
    input  logic             hold,
    input  logic             abort,
    output logic [WIDTH-1:0] bin_out,
    output logic [WIDTH-1:0] gray_out,
    output logic             busy,
    output logic             done,
    output logic             wrap
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2,
        S_DONE = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        OP_RUN   = 2'b00,
        OP_LOAD  = 2'b01,
        OP_CLEAR = 2'b10,
        OP_RSVD  = 2'b11
    } op_e;

    state_e             state_q,     state_d;
    logic [WIDTH-1:0]   count_q,     count_d;
    logic [WIDTH-1:0]   remaining_q, remaining_d;
    logic [PRE_W-1:0]   presc_cnt_q, presc_cnt_d;
    logic [PRE_W-1:0]   presc_lat_q, presc_lat_d;
    logic               wrap_q,      wrap_d;

    // NOTE: every variable gets a default before the case so no path leaves one
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        remaining_d = remaining_q;
        presc_cnt_d = presc_cnt_q;
        presc_lat_d = presc_lat_q;
        wrap_d      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    unique case (op_e'(cmd_op))
                        OP_RUN: begin
                            if (cmd_len == '0) begin
                                state_d = S_DONE;
                            end else begin
                                remaining_d = cmd_len;
                                presc_cnt_d = '0;
                                presc_lat_d = prescale;
                                state_d     = S_RUN;
                            end
                        end
                        OP_LOAD:  count_d = cmd_val;
                        OP_CLEAR: count_d = '0;
                        OP_RSVD:  ;
                    endcase
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (hold) begin
                    state_d = S_HOLD;
                end else if (presc_cnt_q == presc_lat_q) begin
                    count_d     = count_q + WIDTH'(1);
                    wrap_d      = &count_q;
                    remaining_d = remaining_q - WIDTH'(1);
                    presc_cnt_d = '0;
                    if (remaining_q == WIDTH'(1)) begin
                        state_d = S_DONE;
                    end
                end else begin
                    presc_cnt_d = presc_cnt_q + PRE_W'(1);
                end
            end
            // Prescaler phase is kept across a hold so the step cadence resumes.
            S_HOLD: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (!hold) begin
                    state_d = S_RUN;
                end
            end
            S_DONE: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            count_q     <= '0;
            remaining_q <= '0;
            presc_cnt_q <= '0;
            presc_lat_q <= '0;
            wrap_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            remaining_q <= remaining_d;
            presc_cnt_q <= presc_cnt_d;
            presc_lat_q <= presc_lat_d;
            wrap_q      <= wrap_d;
        end
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = (state_q == S_RUN) || (state_q == S_HOLD);
    assign done      = (state_q == S_DONE);
    assign wrap      = wrap_q;
    assign bin_out   = count_q;
    assign gray_out  = count_q ^ (count_q >> 1);

endmodule

// File: tb/tb_gray_seq_ctrl.sv
// Self-checking bench for gray_seq_ctrl: a directed vector table plus hand-written
// sequences for hold, abort and asynchronous reset.
module tb_gray_seq_ctrl;

    localparam int WIDTH = 8;
    localparam int PRE_W = 8;

    localparam logic [1:0] RUN = 2'b00;
    localparam logic [1:0] LDV = 2'b01;
    localparam logic [1:0] CLR = 2'b10;
    localparam logic [1:0] RSV = 2'b11;

    logic             clk = 1'b0;
    logic             reset;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_len;
    logic [WIDTH-1:0] cmd_val;
    logic [PRE_W-1:0] prescale;
    logic             hold;
    logic             abort;
    logic [WIDTH-1:0] bin_out;
    logic [WIDTH-1:0] gray_out;
    logic             busy;
    logic             done;
    logic             wrap;

    int errors = 0;
    int checks = 0;

    gray_seq_ctrl #(.WIDTH(WIDTH), .PRE_W(PRE_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_len   (cmd_len),
        .cmd_val   (cmd_val),
        .prescale  (prescale),
        .hold      (hold),
        .abort     (abort),
        .bin_out   (bin_out),
        .gray_out  (gray_out),
        .busy      (busy),
        .done      (done),
        .wrap      (wrap)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       vld;
        logic [1:0] op;
        logic [7:0] len;
        logic [7:0] val;
        logic [7:0] pre;
        logic       hld;
        logic       abt;
        logic [7:0] e_bin;
        logic [7:0] e_gray;
        logic       e_busy;
        logic       e_done;
        logic       e_wrap;
        logic       e_rdy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(logic vld, logic [1:0] op, logic [7:0] len, logic [7:0] val,
                               logic [7:0] pre, logic hld, logic abt, logic [7:0] e_bin,
                               logic [7:0] e_gray, logic e_busy, logic e_done, logic e_wrap,
                               logic e_rdy);
        vec_t r;
        r.vld = vld; r.op = op; r.len = len; r.val = val; r.pre = pre;
        r.hld = hld; r.abt = abt; r.e_bin = e_bin; r.e_gray = e_gray;
        r.e_busy = e_busy; r.e_done = e_done; r.e_wrap = e_wrap; r.e_rdy = e_rdy;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic vld, input logic [1:0] op, input logic [7:0] len,
                         input logic [7:0] val, input logic [7:0] pre, input logic hld,
                         input logic abt);
        cmd_valid = vld; cmd_op = op; cmd_len = len; cmd_val = val;
        prescale = pre; hold = hld; abort = abt;
    endtask

    task automatic idle_inputs();
        drive(1'b0, RUN, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0);
    endtask

    task automatic check_outs(input string tag, input logic [7:0] e_bin, input logic [7:0] e_gray,
                              input logic e_busy, input logic e_done, input logic e_wrap,
                              input logic e_rdy);
        check({tag, " bin"},   bin_out,   e_bin);
        check({tag, " gray"},  gray_out,  e_gray);
        check({tag, " busy"},  busy,      e_busy);
        check({tag, " done"},  done,      e_done);
        check({tag, " wrap"},  wrap,      e_wrap);
        check({tag, " ready"}, cmd_ready, e_rdy);
    endtask

    initial begin
        reset = 1'b0;
        idle_inputs();

        // Five steps at full rate; CLEAR offered during RUN and DONE must be ignored.
        vecs.push_back(v(1, CLR, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 1));
        vecs.push_back(v(1, RUN, 5, 0, 0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 0));
        vecs.push_back(v(1, CLR, 0, 0, 0, 0, 0, 8'h01, 8'h01, 1, 0, 0, 0));
        vecs.push_back(v(1, CLR, 0, 0, 0, 0, 0, 8'h02, 8'h03, 1, 0, 0, 0));
        vecs.push_back(v(1, CLR, 0, 0, 0, 0, 0, 8'h03, 8'h02, 1, 0, 0, 0));
        vecs.push_back(v(1, CLR, 0, 0, 0, 0, 0, 8'h04, 8'h06, 1, 0, 0, 0));
        vecs.push_back(v(1, CLR, 0, 0, 0, 0, 0, 8'h05, 8'h07, 0, 1, 0, 0));
        vecs.push_back(v(1, CLR, 0, 0, 0, 0, 0, 8'h05, 8'h07, 0, 0, 0, 1));
        vecs.push_back(v(0, CLR, 0, 0, 0, 0, 0, 8'h05, 8'h07, 0, 0, 0, 1));
        vecs.push_back(v(1, RSV, 9, 9, 0, 0, 0, 8'h05, 8'h07, 0, 0, 0, 1));
        // Wrap through all-ones.
        vecs.push_back(v(1, LDV, 0, 8'hFE, 0, 0, 0, 8'hFE, 8'h81, 0, 0, 0, 1));
        vecs.push_back(v(1, RUN, 3, 0, 0, 0, 0, 8'hFE, 8'h81, 1, 0, 0, 0));
        vecs.push_back(v(0, RUN, 0, 0, 0, 0, 0, 8'hFF, 8'h80, 1, 0, 0, 0));
        vecs.push_back(v(0, RUN, 0, 0, 0, 0, 0, 8'h00, 8'h00, 1, 0, 1, 0));
        vecs.push_back(v(0, RUN, 0, 0, 0, 0, 0, 8'h01, 8'h01, 0, 1, 0, 0));
        vecs.push_back(v(0, RUN, 0, 0, 0, 0, 0, 8'h01, 8'h01, 0, 0, 0, 1));
        // Prescale 2: steps every 3 cycles; prescale input changed mid-run.
        vecs.push_back(v(1, CLR, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 1));
        vecs.push_back(v(1, RUN, 2, 0, 2, 0, 0, 8'h00, 8'h00, 1, 0, 0, 0));
        vecs.push_back(v(0, RUN, 0, 0, 0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 0));
        vecs.push_back(v(0, RUN, 0, 0, 0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 0));
        vecs.push_back(v(0, RUN, 0, 0, 0, 0, 0, 8'h01, 8'h01, 1, 0, 0, 0));
        vecs.push_back(v(0, RUN, 0, 0, 0, 0, 0, 8'h01, 8'h01, 1, 0, 0, 0));
        vecs.push_back(v(0, RUN, 0, 0, 0, 0, 0, 8'h01, 8'h01, 1, 0, 0, 0));
        vecs.push_back(v(0, RUN, 0, 0, 0, 0, 0, 8'h02, 8'h03, 0, 1, 0, 0));
        vecs.push_back(v(0, RUN, 0, 0, 0, 0, 0, 8'h02, 8'h03, 0, 0, 0, 1));

        repeat (2) @(negedge clk);
        check("rst bin", bin_out, 8'h00);
        check("rst gray", gray_out, 8'h00);
        check("rst busy", busy, 1'b0);
        check("rst done", done, 1'b0);
        check("rst wrap", wrap, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check("rst ready", cmd_ready, 1'b1);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].vld, vecs[i].op, vecs[i].len, vecs[i].val, vecs[i].pre,
                  vecs[i].hld, vecs[i].abt);
            tick();
            check_outs($sformatf("vec%0d", i), vecs[i].e_bin, vecs[i].e_gray, vecs[i].e_busy,
                       vecs[i].e_done, vecs[i].e_wrap, vecs[i].e_rdy);
        end

        // Hold for three cycles after step 2, then resume to completion.
        drive(1, CLR, 0, 0, 0, 0, 0); tick();
        drive(1, RUN, 4, 0, 0, 0, 0); tick();
        idle_inputs(); tick(); tick();
        check("hold pre bin", bin_out, 8'h02);
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_outs($sformatf("hold%0d", i), 8'h02, 8'h03, 1, 0, 0, 0);
        end
        hold = 1'b0;
        begin
            bit seen = 0;
            for (int i = 0; i < 10 && !seen; i++) begin
                tick();
                if (done) seen = 1;
            end
            check("hold done seen", seen, 1'b1);
            check("hold final bin", bin_out, 8'h04);
        end
        tick();
        check("hold ready", cmd_ready, 1'b1);

        // Abort together with hold after step 3; LOAD offered during RUN is ignored.
        drive(1, CLR, 0, 0, 0, 0, 0); tick();
        drive(1, RUN, 10, 0, 0, 0, 0); tick();
        drive(1, LDV, 0, 8'h55, 0, 0, 0);
        tick(); tick(); tick();
        check("abort pre bin", bin_out, 8'h03);
        drive(0, RUN, 0, 0, 0, 1, 1); tick();
        check_outs("abort", 8'h03, 8'h02, 0, 0, 0, 1);
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            tick();
            check_outs($sformatf("abort idle%0d", i), 8'h03, 8'h02, 0, 0, 0, 1);
        end

        // Abort from HOLD.
        drive(1, RUN, 10, 0, 0, 0, 0); tick();
        idle_inputs(); tick();
        hold = 1'b1; tick();
        check("hold2 busy", busy, 1'b1);
        abort = 1'b1; tick();
        check_outs("abort hold", 8'h04, 8'h06, 0, 0, 0, 1);
        idle_inputs();

        // Asynchronous reset between edges mid-run, then a zero-length RUN.
        drive(1, CLR, 0, 0, 0, 0, 0); tick();
        drive(1, RUN, 10, 0, 0, 0, 0); tick();
        idle_inputs(); tick(); tick(); tick();
        check("arst pre bin", bin_out, 8'h03);
        #2 reset = 1'b0;
        #1;
        check("arst bin", bin_out, 8'h00);
        check("arst gray", gray_out, 8'h00);
        check("arst busy", busy, 1'b0);
        check("arst done", done, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        drive(1, RUN, 0, 0, 0, 0, 0); tick();
        check_outs("len0", 8'h00, 8'h00, 0, 1, 0, 0);
        idle_inputs(); tick();
        check_outs("len0 idle", 8'h00, 8'h00, 0, 0, 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/gray_seq_ctrl.md
Name: gray_seq_ctrl

Overview:
- Command-driven sequencer that owns a WIDTH-bit binary step counter and publishes it as Gray code.
- Accepts RUN/LOAD/CLEAR commands over a valid/ready handshake.
- Steps the counter a programmed number of times at a programmable prescaled rate, with hold and abort controls.
- Signals completion with a one-cycle done pulse; used wherever the design needs a Gray position sequence with a bounded length.

Parameters:
WIDTH, 8, counter / Gray output width (>=2)
PRE_W, 8, prescaler width

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
cmd_valid  input  1  command offered
cmd_ready  output  1  command can be accepted (high only in IDLE)
cmd_op  input  2  00 RUN, 01 LOAD, 10 CLEAR, 11 reserved
cmd_len  input  WIDTH  RUN: number of steps
cmd_val  input  WIDTH  LOAD: binary value to load
prescale  input  PRE_W  step every prescale+1 cycles; sampled at RUN accept
hold  input  1  freeze stepping while high
abort  input  1  terminate RUN/HOLD without done
bin_out  output  WIDTH  binary count register
gray_out  output  WIDTH  bin_out ^ (bin_out >> 1), combinational from register
busy  output  1  state is RUN or HOLD
done  output  1  one-cycle pulse at end of a completed RUN
wrap  output  1  one-cycle pulse when a step takes count from all-ones to 0

Behaviour:
- Reset (reset=0, async): state=IDLE, count=0, remaining=0, presc_cnt=0, latched prescale=0. Outputs: bin_out=0, gray_out=0, busy=0, done=0, wrap=0, cmd_ready=1 once reset is released.
- FSM states: IDLE, RUN, HOLD, DONE.
- Accept: cmd_valid & cmd_ready at a rising edge. Commands are ignored in every other state; cmd_valid may stay high.
- LOAD: count<=cmd_val. CLEAR: count<=0. Reserved op: accepted, no effect. All three stay in IDLE, with the new value on the outputs the next cycle.
- RUN, cmd_len=0: go to DONE, no step taken.
- RUN, cmd_len>0: remaining<=cmd_len, presc_cnt<=0, prescale latched, go to RUN.
- RUN state, each cycle:
  - if abort: go to IDLE.
  - else if hold: go to HOLD; presc_cnt and count frozen.
  - else if presc_cnt==latched prescale: step, i.e. count<=count+1 mod 2^WIDTH, remaining-=1, presc_cnt<=0. If remaining was 1, go to DONE.
  - else presc_cnt+=1.
- HOLD: abort goes to IDLE; hold=0 goes to RUN with presc_cnt kept. Abort has priority over hold.
- DONE: done=1 for exactly this cycle, cmd_ready=0, then IDLE.
- Step timing: with prescale=P, command accepted at edge E0, step k occurs at edge E0+k*(P+1). bin_out and gray_out reflect the step in the following cycle.
- wrap is registered and asserted in the cycle after the wrapping step edge.
- Abort: count keeps its current value; no done.
- Reset mid-operation: immediate return to the reset values.
- prescale input changes during RUN have no effect.

Test Plan:
- Reset, then CLEAR and RUN len=5, P=0 -> gray_out sequence 00,01,03,02,06,07 on consecutive cycles; done high one cycle after the 5th step; cmd_ready back the next cycle.
- LOAD 0xFE then RUN len=3, P=0 -> bin FE,FF,00,01; gray_out 0x81,0x80,0x00,0x01; wrap pulse exactly once, in the cycle bin_out=00.
- RUN len=2, P=2 -> steps 3 cycles apart (bin changes at E0+3 and E0+6); busy high 6 cycles; done at cycle 7.
- RUN len=4, P=0, hold high 3 cycles after step 2 -> count frozen at 2 (gray 03) during HOLD, busy stays 1, remaining two steps resume after release, done still fires.
- RUN len=10, abort after step 3; abort asserted together with hold -> IDLE, bin_out=3, no done, cmd_ready=1; cmd_valid during RUN is not accepted.
- Async reset asserted mid-RUN, between clock edges -> outputs 0 immediately, state IDLE; RUN len=0 afterwards -> done pulse with no step.
